ddr_native_axi_writer: RTL and testbench

DDR_NATIVE_AXI_WRITER -- requirements
Module: ddr_native_axi_writer

---
 rtl/ddr_native_axi_writer.sv | 194 +++++++++++++++++++
 tb/tb_ddr_native_axi_writer.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_native_axi_writer.sv
// Native write controller to AXI4 write master bridge. Beats are buffered in a FWFT FIFO
// and issued as INCR bursts split at 4 KB boundaries, one transaction in flight at a time.
module ddr_native_axi_writer #(
    parameter int unsigned g_DDR_AXI_DWIDTH = 512,
    parameter int unsigned g_AXI_AWIDTH     = 38,
    parameter int unsigned g_BUF_AWIDTH     = 8
) (
    input  logic                            ddr_clk_i,
    input  logic                            ddr_clk_rst_i,
    input  logic                            write_req_i,
    input  logic [7:0]                      burst_size_i,
    input  logic [g_AXI_AWIDTH-1:0]         write_start_addr_i,
    input  logic                            data_valid_i,
    input  logic [g_DDR_AXI_DWIDTH-1:0]     data_i,
    output logic                            write_ackn_o,
    output logic                            write_done_o,
    output logic                            error_o,
    output logic [g_AXI_AWIDTH-1:0]         awaddr_o,
    output logic [7:0]                      awlen_o,
    output logic [2:0]                      awsize_o,
    output logic [1:0]                      awburst_o,
    output logic [3:0]                      awid_o,
    output logic                            awvalid_o,
    input  logic                            awready_i,
    output logic [g_DDR_AXI_DWIDTH-1:0]     wdata_o,
    output logic [g_DDR_AXI_DWIDTH/8-1:0]   wstrb_o,
    output logic                            wlast_o,
    output logic                            wvalid_o,
    input  logic                            wready_i,
    input  logic [1:0]                      bresp_i,
    input  logic                            bvalid_i,
    output logic                            bready_o
);
    localparam int unsigned BeatLog2  = $clog2(g_DDR_AXI_DWIDTH / 8);
    localparam int unsigned PageBeats = 4096 / (g_DDR_AXI_DWIDTH / 8);
    localparam int unsigned BufDepth  = 2 ** g_BUF_AWIDTH;

    typedef enum logic [2:0] {StIdle, StAck, StAddr, StData, StResp} state_e;

    state_e                         state_q, state_d;
    logic [g_AXI_AWIDTH-1:0]        addr_q, addr_d, addr_next, addr_step;
    logic [8:0]                     rem_q, rem_d;
    logic [7:0]                     awlen_q, awlen_d;
    logic [7:0]                     beat_q, beat_d;
    logic                           error_q, error_d;
    logic                           done_q, done_d;

    logic [g_DDR_AXI_DWIDTH-1:0]    mem_q [BufDepth];
    logic [g_BUF_AWIDTH-1:0]        wr_ptr_q, rd_ptr_q;
    logic [g_BUF_AWIDTH:0]          count_q, count_d;
    logic                           fifo_full, fifo_empty, fifo_wr, fifo_rd;
    logic                           aw_hs, w_hs, b_hs;
    logic                           unused_addr_lsbs;

    // Sub-burst length minus one: limited by remaining beats and room left in the 4 KB page.
    function automatic logic [7:0] sub_len_m1(input logic [g_AXI_AWIDTH-1:0] addr,
                                              input logic [8:0]              rem);
        logic [8:0] room;
        room = 9'(PageBeats) - 9'(addr[11:BeatLog2]);
        return (rem < room) ? 8'(rem - 9'd1) : 8'(room - 9'd1);
    endfunction

    assign unused_addr_lsbs = ^write_start_addr_i[BeatLog2-1:0];

    // Count never exceeds BufDepth, so its MSB alone marks full.
    assign fifo_full  = count_q[g_BUF_AWIDTH];
    assign fifo_empty = (count_q == '0);
    assign fifo_wr    = data_valid_i & ~fifo_full;
    assign fifo_rd    = w_hs;

    assign aw_hs = awvalid_o & awready_i;
    assign w_hs  = wvalid_o & wready_i;
    assign b_hs  = bready_o & bvalid_i;

    assign awaddr_o     = addr_q;
    assign awlen_o      = awlen_q;
    assign awsize_o     = 3'(BeatLog2);
    assign awburst_o    = 2'b01;
    assign awid_o       = '0;
    assign wstrb_o      = '1;
    assign wdata_o      = mem_q[rd_ptr_q];
    assign error_o      = error_q;
    assign write_done_o = done_q;

    always_ff @(posedge ddr_clk_i) begin
        if (ddr_clk_rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (write_req_i) state_d = StAck;
            StAck:   state_d = StAddr;
            StAddr:  if (aw_hs) state_d = StData;
            StData:  if (w_hs && wlast_o) state_d = StResp;
            StResp:  if (b_hs) state_d = (rem_q == '0) ? StIdle : StAddr;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        write_ackn_o = 1'b0;
        awvalid_o    = 1'b0;
        wvalid_o     = 1'b0;
        wlast_o      = 1'b0;
        bready_o     = 1'b0;
        unique case (state_q)
            StAck:  write_ackn_o = 1'b1;
            StAddr: awvalid_o    = 1'b1;
            StData: begin
                wvalid_o = ~fifo_empty;
                wlast_o  = ~fifo_empty && (beat_q == awlen_q);
            end
            StResp: bready_o = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        addr_step = (g_AXI_AWIDTH'(awlen_q) + g_AXI_AWIDTH'(1)) << BeatLog2;
        addr_next = addr_q + addr_step;
        addr_d    = addr_q;
        rem_d     = rem_q;
        awlen_d   = awlen_q;
        beat_d    = beat_q;
        done_d    = 1'b0;
        error_d   = error_q | (data_valid_i & fifo_full);
        unique case (state_q)
            StIdle: begin
                if (write_req_i) begin
                    addr_d = {write_start_addr_i[g_AXI_AWIDTH-1:BeatLog2], {BeatLog2{1'b0}}};
                    rem_d  = (burst_size_i == '0) ? 9'd256 : {1'b0, burst_size_i};
                end
            end
            StAck:  awlen_d = sub_len_m1(addr_q, rem_q);
            StAddr: if (aw_hs) rem_d = rem_q - 9'(awlen_q) - 9'd1;
            StData: if (w_hs) beat_d = wlast_o ? 8'd0 : beat_q + 8'd1;
            StResp: begin
                if (b_hs) begin
                    if (bresp_i != 2'b00) error_d = 1'b1;
                    if (rem_q == '0) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d  = addr_next;
                        awlen_d = sub_len_m1(addr_next, rem_q);
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        count_d = count_q;
        unique case ({fifo_wr, fifo_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge ddr_clk_i) begin
        if (ddr_clk_rst_i) begin
            addr_q   <= '0;
            rem_q    <= '0;
            awlen_q  <= '0;
            beat_q   <= '0;
            error_q  <= 1'b0;
            done_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            awlen_q  <= awlen_d;
            beat_q   <= beat_d;
            error_q  <= error_d;
            done_q   <= done_d;
            count_q  <= count_d;
            if (fifo_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (fifo_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge ddr_clk_i) begin
        if (fifo_wr) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: tb/tb_ddr_native_axi_writer.sv
// Self-checking bench for ddr_native_axi_writer: directed table, corner sequences and random
// transactions scored against a burst-splitting model and an in-order beat scoreboard.
module tb_ddr_native_axi_writer;
    typedef struct packed {
        logic [37:0] addr;
        logic [7:0]  len;
    } burst_t;

    typedef struct {
        logic [37:0] addr;
        logic [7:0]  size;
        int          aw_pct;
        int          w_pct;
        int          b_pct;
        int          gap;
        bit          preload;
        logic [1:0]  bresp;
        bit          exp_err;
    } vec_t;

    logic ddr_clk_i, ddr_clk_rst_i, write_req_i, data_valid_i;
    logic [7:0] burst_size_i;
    logic [37:0] write_start_addr_i;
    logic [511:0] data_i;
    logic write_ackn_o, write_done_o, error_o;
    logic [37:0] awaddr_o;
    logic [7:0] awlen_o;
    logic [2:0] awsize_o;
    logic [1:0] awburst_o;
    logic [3:0] awid_o;
    logic awvalid_o, awready_i;
    logic [511:0] wdata_o;
    logic [63:0] wstrb_o;
    logic wlast_o, wvalid_o, wready_i;
    logic [1:0] bresp_i;
    logic bvalid_i, bready_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int aw_pct = 100, w_pct = 100, b_pct = 100;
    logic [1:0] bresp_val = 2'b00;
    int pend_b = 0, w_idx = 0, w_taken = 0, w_limit = 1 << 30;
    int ackn_cnt = 0, done_cnt = 0, b_cnt = 0;
    int ackn_cyc = 0, done_cyc = 0, last_b_cyc = 0, req_cyc = 0;
    logic [7:0] cur_len = 8'd0;
    bit aw_wait = 0, w_wait = 0;
    logic [37:0] prev_awaddr;
    logic [7:0] prev_awlen;
    logic [511:0] prev_wdata;
    logic prev_wlast;

    burst_t exp_bursts[$];
    logic [511:0] exp_data[$];
    vec_t tbl[6];

    ddr_native_axi_writer #(
        .g_DDR_AXI_DWIDTH(512),
        .g_AXI_AWIDTH    (38),
        .g_BUF_AWIDTH    (8)
    ) dut (
        .ddr_clk_i         (ddr_clk_i),
        .ddr_clk_rst_i     (ddr_clk_rst_i),
        .write_req_i       (write_req_i),
        .burst_size_i      (burst_size_i),
        .write_start_addr_i(write_start_addr_i),
        .data_valid_i      (data_valid_i),
        .data_i            (data_i),
        .write_ackn_o      (write_ackn_o),
        .write_done_o      (write_done_o),
        .error_o           (error_o),
        .awaddr_o          (awaddr_o),
        .awlen_o           (awlen_o),
        .awsize_o          (awsize_o),
        .awburst_o         (awburst_o),
        .awid_o            (awid_o),
        .awvalid_o         (awvalid_o),
        .awready_i         (awready_i),
        .wdata_o           (wdata_o),
        .wstrb_o           (wstrb_o),
        .wlast_o           (wlast_o),
        .wvalid_o          (wvalid_o),
        .wready_i          (wready_i),
        .bresp_i           (bresp_i),
        .bvalid_i          (bvalid_i),
        .bready_o          (bready_o)
    );

    initial ddr_clk_i = 1'b0;
    always #5 ddr_clk_i = ~ddr_clk_i;
    always @(posedge ddr_clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_wide(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input int val);
        checks++;
        errors++;
        $display("FAIL %s: got %0d, expected none", name, val);
    endtask

    function automatic logic [511:0] rand_beat();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference: split a request into INCR bursts that never cross a 4 KB page.
    task automatic build_model(input logic [37:0] addr, input logic [7:0] size, output int nb);
        logic [37:0] a;
        int rem, room, n;
        a   = addr & ~38'h3F;
        rem = (size == 8'd0) ? 256 : int'(size);
        nb  = 0;
        while (rem > 0) begin
            room = 64 - int'(a[11:6]);
            n    = (rem < room) ? rem : room;
            exp_bursts.push_back('{addr: a, len: 8'(n - 1)});
            a    = a + 38'(n * 64);
            rem  = rem - n;
            nb++;
        end
    endtask

    // AXI slave responder plus protocol/scoreboard monitor, sampled 3 ns after the falling edge.
    initial begin
        awready_i = 1'b0;
        wready_i  = 1'b0;
        bvalid_i  = 1'b0;
        bresp_i   = 2'b00;
        forever begin
            @(negedge ddr_clk_i);
            awready_i = ($urandom_range(99) < aw_pct);
            wready_i  = (w_taken < w_limit) && ($urandom_range(99) < w_pct);
            bvalid_i  = (pend_b > 0) && ($urandom_range(99) < b_pct);
            bresp_i   = bvalid_i ? bresp_val : 2'b00;
            #3;
            if (ddr_clk_rst_i) begin
                pend_b  = 0;
                w_idx   = 0;
                aw_wait = 0;
                w_wait  = 0;
            end else begin
                if (aw_wait) begin
                    chk("awvalid_held", awvalid_o, 1);
                    chk("awaddr_stable", awaddr_o, prev_awaddr);
                    chk("awlen_stable", awlen_o, prev_awlen);
                end
                if (w_wait) begin
                    chk("wvalid_held", wvalid_o, 1);
                    chk_wide("wdata_stable", wdata_o, prev_wdata);
                    chk("wlast_stable", wlast_o, prev_wlast);
                end
                if (awvalid_o && awready_i) begin
                    chk("one_outstanding", pend_b, 0);
                    if (exp_bursts.size() == 0) flag("aw_unexpected", int'(awaddr_o));
                    else begin
                        burst_t b;
                        b = exp_bursts.pop_front();
                        chk("awaddr", awaddr_o, b.addr);
                        chk("awlen", awlen_o, b.len);
                        cur_len = b.len;
                        w_idx   = 0;
                    end
                end
                if (wvalid_o && wready_i) begin
                    if (exp_data.size() == 0) flag("w_unexpected", w_taken);
                    else chk_wide("wdata", wdata_o, exp_data.pop_front());
                    chk("wlast", wlast_o, (w_idx == int'(cur_len)));
                    w_idx++;
                    w_taken++;
                    if (wlast_o) pend_b++;
                end
                if (bvalid_i && bready_o) begin
                    pend_b--;
                    b_cnt++;
                    last_b_cyc = cyc;
                end
                if (write_ackn_o) begin
                    ackn_cnt++;
                    ackn_cyc = cyc;
                end
                if (write_done_o) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                aw_wait     = awvalid_o && !awready_i;
                prev_awaddr = awaddr_o;
                prev_awlen  = awlen_o;
                w_wait      = wvalid_o && !wready_i;
                prev_wdata  = wdata_o;
                prev_wlast  = wlast_o;
            end
        end
    end

    task automatic do_reset();
        @(negedge ddr_clk_i);
        ddr_clk_rst_i = 1'b1;
        write_req_i   = 1'b0;
        data_valid_i  = 1'b0;
        repeat (2) @(negedge ddr_clk_i);
        ddr_clk_rst_i = 1'b0;
    endtask

    task automatic send_beats(input int n, input int gap, input bit track);
        for (int i = 0; i < n; i++) begin
            @(negedge ddr_clk_i);
            while ($urandom_range(99) < gap) begin
                data_valid_i = 1'b0;
                @(negedge ddr_clk_i);
            end
            data_i       = rand_beat();
            data_valid_i = 1'b1;
            if (track) exp_data.push_back(data_i);
        end
        @(negedge ddr_clk_i);
        data_valid_i = 1'b0;
    endtask

    task automatic do_req(input logic [37:0] addr, input logic [7:0] size);
        int t;
        @(negedge ddr_clk_i);
        write_req_i        = 1'b1;
        burst_size_i       = size;
        write_start_addr_i = addr;
        req_cyc            = cyc;
        t = 0;
        while (ackn_cnt == 0 && t < 50) begin
            @(negedge ddr_clk_i);
            t++;
        end
        write_req_i = 1'b0;
        chk("ackn_seen", ackn_cnt, 1);
        chk("ackn_latency", ackn_cyc - req_cyc, 1);
    endtask

    task automatic run_txn(input vec_t v);
        int nb, total, t;
        exp_bursts.delete();
        exp_data.delete();
        ackn_cnt  = 0;
        done_cnt  = 0;
        b_cnt     = 0;
        aw_pct    = v.aw_pct;
        w_pct     = v.w_pct;
        b_pct     = v.b_pct;
        bresp_val = v.bresp;
        build_model(v.addr, v.size, nb);
        total = (v.size == 8'd0) ? 256 : int'(v.size);
        if (v.preload) begin
            send_beats(total, v.gap, 1'b1);
            do_req(v.addr, v.size);
        end else begin
            fork
                send_beats(total, v.gap, 1'b1);
                do_req(v.addr, v.size);
            join
        end
        t = 0;
        while (done_cnt == 0 && t < 20000) begin
            @(negedge ddr_clk_i);
            t++;
        end
        repeat (4) @(negedge ddr_clk_i);
        chk("done_count", done_cnt, 1);
        chk("done_latency", done_cyc - last_b_cyc, 1);
        chk("b_count", b_cnt, nb);
        chk("aw_left", exp_bursts.size(), 0);
        chk("w_left", exp_data.size(), 0);
        chk("error_o", error_o, v.exp_err);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int nb, t;
        logic [63:0] r64;

        tbl[0] = '{38'h0_0000_1000, 8'd30,  100, 100, 100, 0,  1'b0, 2'b00, 1'b0};
        tbl[1] = '{38'h0_0000_0FC0, 8'd4,   100, 100, 100, 0,  1'b0, 2'b00, 1'b0};
        tbl[2] = '{38'h0_0000_0000, 8'd0,   100, 100, 100, 0,  1'b1, 2'b00, 1'b0};
        tbl[3] = '{38'h1_2345_6FC0, 8'd200, 50,  50,  50,  30, 1'b0, 2'b00, 1'b0};
        tbl[4] = '{38'h0_0000_07D5, 8'd64,  60,  40,  70,  0,  1'b1, 2'b00, 1'b0};
        tbl[5] = '{38'h0_0000_2000, 8'd8,   100, 100, 100, 0,  1'b0, 2'b10, 1'b1};

        ddr_clk_rst_i      = 1'b1;
        write_req_i        = 1'b0;
        burst_size_i       = 8'd0;
        write_start_addr_i = '0;
        data_valid_i       = 1'b0;
        data_i             = '0;
        repeat (3) @(negedge ddr_clk_i);
        #3;
        chk("rst_awvalid", awvalid_o, 0);
        chk("rst_wvalid", wvalid_o, 0);
        chk("rst_wlast", wlast_o, 0);
        chk("rst_bready", bready_o, 0);
        chk("rst_ackn", write_ackn_o, 0);
        chk("rst_done", write_done_o, 0);
        chk("rst_error", error_o, 0);
        chk("rst_awaddr", awaddr_o, 0);
        chk("rst_awlen", awlen_o, 0);
        chk("awsize", awsize_o, 6);
        chk("awburst", awburst_o, 1);
        chk("awid", awid_o, 0);
        chk("wstrb", wstrb_o, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge ddr_clk_i);
        ddr_clk_rst_i = 1'b0;

        for (int i = 0; i < 6; i++) begin
            do_reset();
            run_txn(tbl[i]);
        end

        // Error from the previous BRESP must survive a clean transaction.
        v = tbl[0];
        v.exp_err = 1'b1;
        run_txn(v);

        // Overflow: 256 beats fill the buffer, the 257th is dropped and flags an error.
        do_reset();
        send_beats(256, 0, 1'b0);
        chk("error_at_256", error_o, 0);
        send_beats(1, 0, 1'b0);
        chk("error_overflow", error_o, 1);
        chk("wvalid_no_req", wvalid_o, 0);
        do_reset();
        chk("error_cleared", error_o, 0);

        // Reset in DATA after 5 of 20 beats.
        exp_bursts.delete();
        exp_data.delete();
        ackn_cnt  = 0;
        aw_pct    = 100;
        w_pct     = 100;
        b_pct     = 100;
        bresp_val = 2'b00;
        w_limit   = w_taken + 5;
        build_model(38'h0, 8'd20, nb);
        send_beats(20, 0, 1'b1);
        do_req(38'h0, 8'd20);
        t = 0;
        while (w_taken < w_limit && t < 200) begin
            @(negedge ddr_clk_i);
            t++;
        end
        chk("beats_before_reset", exp_data.size(), 15);
        ddr_clk_rst_i = 1'b1;
        @(negedge ddr_clk_i);
        #3;
        chk("mid_rst_awvalid", awvalid_o, 0);
        chk("mid_rst_wvalid", wvalid_o, 0);
        chk("mid_rst_wlast", wlast_o, 0);
        chk("mid_rst_bready", bready_o, 0);
        chk("mid_rst_ackn", write_ackn_o, 0);
        chk("mid_rst_awaddr", awaddr_o, 0);
        chk("mid_rst_awlen", awlen_o, 0);
        chk("mid_rst_no_more_w", exp_data.size(), 15);
        @(negedge ddr_clk_i);
        ddr_clk_rst_i = 1'b0;
        w_limit = 1 << 30;
        v = '{38'h0_0000_5000, 8'd20, 100, 100, 100, 0, 1'b0, 2'b00, 1'b0};
        run_txn(v);

        // Randomized transactions with backpressure.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            r64       = {$urandom, $urandom};
            v.addr    = r64[37:0];
            v.size    = 8'($urandom_range(255));
            v.aw_pct  = $urandom_range(100, 30);
            v.w_pct   = $urandom_range(100, 30);
            v.b_pct   = $urandom_range(100, 30);
            v.gap     = $urandom_range(40);
            v.preload = 1'($urandom_range(1));
            v.bresp   = 2'b00;
            v.exp_err = 1'b0;
            run_txn(v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
